// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared writeback types, load funct3 codes and FSM states
package writeback_stage_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wbsel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE,
      WB_WAIT_LOAD
   } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - retire handshake, load response and register-file write port
interface writeback_stage_if #(
   parameter int DWIDTH = 32
);
   logic              valid_i;
   logic              ready_o;
   logic [4:0]        rd_i;
   logic              regwr_i;
   logic [1:0]        wbsel_i;
   logic [2:0]        funct3_i;
   logic [DWIDTH-1:0] alu_i;
   logic [DWIDTH-1:0] pc_i;
   logic              mem_rvalid_i;
   logic [DWIDTH-1:0] mem_rdata_i;
   logic [4:0]        rd_o;
   logic [DWIDTH-1:0] datawb_o;
   logic              regwren_o;
   logic              err_o;
   logic [31:0]       retire_cnt_o;

   modport master (
      output valid_i, rd_i, regwr_i, wbsel_i, funct3_i, alu_i, pc_i, mem_rvalid_i, mem_rdata_i,
      input  ready_o, rd_o, datawb_o, regwren_o, err_o, retire_cnt_o
   );

   modport slave (
      input  valid_i, rd_i, regwr_i, wbsel_i, funct3_i, alu_i, pc_i, mem_rvalid_i, mem_rdata_i,
      output ready_o, rd_o, datawb_o, regwren_o, err_o, retire_cnt_o
   );
endinterface

// File: rtl/writeback_stage_load_align.sv
// rtl/writeback_stage_load_align.sv - extracts and extends load data from an aligned word
module load_align
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        off,
   input  logic [DWIDTH-1:0] word,
   output logic [DWIDTH-1:0] data,
   output logic              bad
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = word[{off, 3'b000} +: 8];
   assign half_v = word[{off[1], 4'b0000} +: 16];

   always_comb begin
      data = '0;
      bad  = 1'b0;
      case (funct3)
         F3_LB:   data = {{(DWIDTH-8){byte_v[7]}}, byte_v};
         F3_LBU:  data = {{(DWIDTH-8){1'b0}}, byte_v};
         F3_LH: begin
            data = {{(DWIDTH-16){half_v[15]}}, half_v};
            bad  = off[0];
         end
         F3_LHU: begin
            data = {{(DWIDTH-16){1'b0}}, half_v};
            bad  = off[0];
         end
         F3_LW: begin
            data = word;
            bad  = (off != 2'b00);
         end
         default: bad = 1'b1;
      endcase
   end
endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage: source select, load wait with timeout,
// registered register-file write port and retirement counter
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   writeback_stage_if.slave wb
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   wb_state_e         state, state_nx;
   logic [4:0]        ld_rd;
   logic              ld_regwr;
   logic [2:0]        ld_f3;
   logic [1:0]        ld_off;
   logic [TW-1:0]     tcnt;
   logic [4:0]        rd_q;
   logic [DWIDTH-1:0] data_q;
   logic              wren_q;
   logic              err_q;
   logic [31:0]       cnt_q;

   logic              accept, is_mem;
   logic [2:0]        al_f3;
   logic [1:0]        al_off;
   logic [DWIDTH-1:0] al_data;
   logic              al_bad;

   logic              retire, wr_en, set_err, tick;
   logic [4:0]        wr_rd;
   logic [DWIDTH-1:0] wr_data;

   assign accept = wb.valid_i && (state == WB_IDLE);
   assign is_mem = (wb.wbsel_i == WB_MEM);

   // One aligner serves both the accept-time legality check and the response path.
   assign al_f3  = (state == WB_IDLE) ? wb.funct3_i   : ld_f3;
   assign al_off = (state == WB_IDLE) ? wb.alu_i[1:0] : ld_off;

   load_align #(.DWIDTH(DWIDTH)) u_align (
      .funct3 (al_f3),
      .off    (al_off),
      .word   (wb.mem_rdata_i),
      .data   (al_data),
      .bad    (al_bad)
   );

   always_comb begin
      state_nx = state;
      retire   = 1'b0;
      wr_en    = 1'b0;
      wr_rd    = '0;
      wr_data  = '0;
      set_err  = 1'b0;
      tick     = 1'b0;
      case (state)
         WB_IDLE: begin
            if (wb.valid_i) begin
               if (is_mem) begin
                  if (al_bad) set_err  = 1'b1;
                  else        state_nx = WB_WAIT_LOAD;
               end else begin
                  retire  = 1'b1;
                  wr_rd   = wb.rd_i;
                  wr_en   = wb.regwr_i && (wb.rd_i != 5'd0);
                  wr_data = (wb.wbsel_i == WB_PC4) ? wb.pc_i + DWIDTH'(4) : wb.alu_i;
               end
            end
         end
         WB_WAIT_LOAD: begin
            if (wb.mem_rvalid_i) begin
               retire   = 1'b1;
               wr_rd    = ld_rd;
               wr_en    = ld_regwr && (ld_rd != 5'd0);
               wr_data  = al_data;
               state_nx = WB_IDLE;
            end else begin
               tick = 1'b1;
               if (tcnt + TW'(1) == TW'(MEM_TIMEOUT)) begin
                  set_err  = 1'b1;
                  state_nx = WB_IDLE;
               end
            end
         end
         default: state_nx = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WB_IDLE;
         ld_rd    <= '0;
         ld_regwr <= 1'b0;
         ld_f3    <= '0;
         ld_off   <= '0;
         tcnt     <= '0;
         rd_q     <= '0;
         data_q   <= '0;
         wren_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state  <= state_nx;
         wren_q <= retire && wr_en;
         if (retire) begin
            rd_q   <= wr_rd;
            data_q <= wr_data;
            cnt_q  <= cnt_q + 32'd1;
         end
         if (set_err) err_q <= 1'b1;
         if (accept && is_mem) begin
            ld_rd    <= wb.rd_i;
            ld_regwr <= wb.regwr_i;
            ld_f3    <= wb.funct3_i;
            ld_off   <= wb.alu_i[1:0];
            tcnt     <= '0;
         end else if (tick) begin
            tcnt <= tcnt + TW'(1);
         end
      end
   end

   assign wb.ready_o      = (state == WB_IDLE);
   assign wb.rd_o         = rd_q;
   assign wb.datawb_o     = data_q;
   assign wb.regwren_o    = wren_q;
   assign wb.err_o        = err_q;
   assign wb.retire_cnt_o = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;
   import writeback_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   writeback_stage_if #(.DWIDTH(32)) bus ();

   writeback_stage #(.DWIDTH(32), .MEM_TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned exp_cnt;
   logic        exp_err;

   typedef struct {
      logic [4:0]  rd;
      logic        regwr;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] word;
      int          lat;
      logic        bad;
      logic [31:0] data;
   } load_t;

   // Reference load semantics expressed as shifts and masks on the response word.
   function automatic logic ref_load(input logic [2:0] f3, input logic [1:0] off,
                                     input logic [31:0] word, output logic [31:0] data);
      logic [31:0] b, h;
      b = (word >> (off * 8)) & 32'h0000_00FF;
      h = (word >> (off * 8)) & 32'h0000_FFFF;
      data = 32'h0;
      case (f3)
         3'd0: begin data = b[7]  ? (b | 32'hFFFF_FF00) : b; return 1'b0; end
         3'd4: begin data = b; return 1'b0; end
         3'd1: begin data = h[15] ? (h | 32'hFFFF_0000) : h; return (off % 2) != 0; end
         3'd5: begin data = h; return (off % 2) != 0; end
         3'd2: begin data = word; return off != 0; end
         default: return 1'b1;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.valid_i      = 1'b0;
      bus.rd_i         = '0;
      bus.regwr_i      = 1'b0;
      bus.wbsel_i      = WB_ALU;
      bus.funct3_i     = '0;
      bus.alu_i        = '0;
      bus.pc_i         = '0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      exp_cnt = 0;
      exp_err = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({bus.ready_o, bus.regwren_o, bus.err_o, bus.rd_o, bus.datawb_o, bus.retire_cnt_o}
          !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL reset_state got rdy=%b wren=%b err=%b rd=%0d data=%h cnt=%0d want 1 0 0 0 0 0",
                  bus.ready_o, bus.regwren_o, bus.err_o, bus.rd_o, bus.datawb_o, bus.retire_cnt_o);
      end
   endtask

   task automatic test_alu_back_to_back();
      logic        exp_en;
      logic [31:0] exp_d;
      logic [4:0]  exp_rd;
      bus.valid_i = 1'b1; bus.regwr_i = 1'b1; bus.wbsel_i = WB_ALU;
      bus.rd_i = 5'd5; bus.alu_i = 32'h1234;
      step();
      n_cmp++;
      if ({bus.regwren_o, bus.rd_o, bus.datawb_o} !== {1'b1, 5'd5, 32'h1234}) begin
         n_bad++;
         $display("FAIL b2b_first got wren=%b rd=%0d data=%h want 1 5 00001234",
                  bus.regwren_o, bus.rd_o, bus.datawb_o);
      end
      bus.rd_i = 5'd6; bus.alu_i = 32'hABCD;
      step();
      bus.valid_i = 1'b0;
      n_cmp++;
      if ({bus.regwren_o, bus.rd_o, bus.datawb_o} !== {1'b1, 5'd6, 32'hABCD}) begin
         n_bad++;
         $display("FAIL b2b_second got wren=%b rd=%0d data=%h want 1 6 0000abcd",
                  bus.regwren_o, bus.rd_o, bus.datawb_o);
      end
      exp_cnt += 2;
      step();
      n_cmp++;
      if ({bus.regwren_o, bus.retire_cnt_o} !== {1'b0, 32'd2}) begin
         n_bad++;
         $display("FAIL b2b_count got wren=%b cnt=%0d want 0 2", bus.regwren_o, bus.retire_cnt_o);
      end
      for (int i = 0; i < 40; i++) begin
         bus.valid_i = ($urandom % 4) != 0;
         bus.wbsel_i = 2'($urandom_range(0, 3));
         if (bus.wbsel_i == WB_MEM) bus.wbsel_i = 2'b11;
         bus.rd_i    = 5'($urandom);
         bus.regwr_i = 1'($urandom);
         bus.alu_i   = $urandom;
         bus.pc_i    = $urandom;
         exp_en = bus.valid_i && bus.regwr_i && (bus.rd_i != 0);
         exp_rd = bus.rd_i;
         exp_d  = (bus.wbsel_i == WB_PC4) ? bus.pc_i + 32'd4 : bus.alu_i;
         if (bus.valid_i) exp_cnt++;
         step();
         n_cmp++;
         if ({bus.ready_o, bus.regwren_o, bus.retire_cnt_o} !== {1'b1, exp_en, exp_cnt}) begin
            n_bad++;
            $display("FAIL rand_alu_ctl[%0d] got rdy=%b wren=%b cnt=%0d want 1 %b %0d",
                     i, bus.ready_o, bus.regwren_o, bus.retire_cnt_o, exp_en, exp_cnt);
         end
         if (exp_en) begin
            n_cmp++;
            if ({bus.rd_o, bus.datawb_o} !== {exp_rd, exp_d}) begin
               n_bad++;
               $display("FAIL rand_alu_data[%0d] got rd=%0d data=%h want %0d %h",
                        i, bus.rd_o, bus.datawb_o, exp_rd, exp_d);
            end
         end
      end
      bus.valid_i = 1'b0;
      step();
   endtask

   task automatic test_pc4_x0();
      bus.valid_i = 1'b1; bus.regwr_i = 1'b1; bus.wbsel_i = WB_PC4;
      bus.rd_i = 5'd1; bus.pc_i = 32'hFFFF_FFFC;
      step();
      exp_cnt++;
      n_cmp++;
      if ({bus.regwren_o, bus.rd_o, bus.datawb_o} !== {1'b1, 5'd1, 32'h0}) begin
         n_bad++;
         $display("FAIL pc4_wrap got wren=%b rd=%0d data=%h want 1 1 00000000",
                  bus.regwren_o, bus.rd_o, bus.datawb_o);
      end
      bus.wbsel_i = WB_ALU; bus.rd_i = 5'd0; bus.alu_i = 32'hDEAD_BEEF;
      step();
      bus.valid_i = 1'b0;
      exp_cnt++;
      n_cmp++;
      if ({bus.regwren_o, bus.retire_cnt_o} !== {1'b0, exp_cnt}) begin
         n_bad++;
         $display("FAIL x0_write got wren=%b cnt=%0d want 0 %0d", bus.regwren_o, bus.retire_cnt_o, exp_cnt);
      end
      step();
   endtask

   task automatic test_loads();
      load_t q[$];
      load_t t;
      logic [31:0] d;
      logic [31:0] dir_data [4] = '{32'hFFFF_FFF2, 32'h0000_0080, 32'hFFFF_8081, 32'h8081_F27F};
      logic [2:0]  dir_f3   [4] = '{F3_LB, F3_LBU, F3_LH, F3_LW};
      logic [1:0]  dir_off  [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
      for (int i = 0; i < 4; i++) begin
         t = '{rd: 5'(10 + i), regwr: 1'b1, f3: dir_f3[i], off: dir_off[i],
               word: 32'h8081_F27F, lat: 3, bad: 1'b0, data: dir_data[i]};
         q.push_back(t);
      end
      for (int i = 0; i < 30; i++) begin
         t.rd = 5'($urandom); t.regwr = 1'($urandom); t.off = 2'($urandom);
         t.f3 = 3'($urandom); t.word = $urandom; t.lat = $urandom_range(1, 6);
         t.bad = ref_load(t.f3, t.off, t.word, d);
         t.data = d;
         q.push_back(t);
      end
      foreach (q[n]) begin
         t = q[n];
         bus.valid_i = 1'b1; bus.wbsel_i = WB_MEM; bus.rd_i = t.rd; bus.regwr_i = t.regwr;
         bus.funct3_i = t.f3; bus.alu_i = {30'($urandom), t.off}; bus.pc_i = $urandom;
         n_cmp++;
         if (bus.ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL load_ready_before[%0d] got %b want 1", n, bus.ready_o);
         end
         step();
         bus.valid_i = 1'b0;
         bus.rd_i = 5'($urandom); bus.funct3_i = 3'($urandom); bus.alu_i = $urandom;
         if (t.bad) begin
            exp_err = 1'b1;
            n_cmp++;
            if ({bus.err_o, bus.ready_o, bus.regwren_o, bus.retire_cnt_o} !== {2'b11, 1'b0, exp_cnt}) begin
               n_bad++;
               $display("FAIL load_bad[%0d] got err=%b rdy=%b wren=%b cnt=%0d want 1 1 0 %0d",
                        n, bus.err_o, bus.ready_o, bus.regwren_o, bus.retire_cnt_o, exp_cnt);
            end
            continue;
         end
         n_cmp++;
         if ({bus.ready_o, bus.regwren_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL load_wait_entry[%0d] got rdy=%b wren=%b want 0 0", n, bus.ready_o, bus.regwren_o);
         end
         for (int k = 1; k < t.lat; k++) begin
            bus.mem_rdata_i = $urandom;
            step();
            n_cmp++;
            if ({bus.ready_o, bus.regwren_o} !== 2'b00) begin
               n_bad++;
               $display("FAIL load_wait[%0d.%0d] got rdy=%b wren=%b want 0 0", n, k, bus.ready_o, bus.regwren_o);
            end
         end
         bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = t.word;
         step();
         bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = $urandom;
         exp_cnt++;
         n_cmp++;
         if ({bus.ready_o, bus.regwren_o, bus.err_o, bus.retire_cnt_o}
             !== {1'b1, t.regwr && (t.rd != 0), exp_err, exp_cnt}) begin
            n_bad++;
            $display("FAIL load_done[%0d] got rdy=%b wren=%b err=%b cnt=%0d want 1 %b %b %0d", n,
                     bus.ready_o, bus.regwren_o, bus.err_o, bus.retire_cnt_o,
                     t.regwr && (t.rd != 0), exp_err, exp_cnt);
         end
         if (t.regwr && (t.rd != 0)) begin
            n_cmp++;
            if ({bus.rd_o, bus.datawb_o} !== {t.rd, t.data}) begin
               n_bad++;
               $display("FAIL load_data[%0d] f3=%0d off=%0d got rd=%0d data=%h want %0d %h", n,
                        t.f3, t.off, bus.rd_o, bus.datawb_o, t.rd, t.data);
            end
         end
      end
   endtask

   task automatic test_errors();
      logic [2:0] f3s [2]  = '{F3_LW, 3'b011};
      logic [1:0] offs [2] = '{2'd2, 2'd0};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         bus.valid_i = 1'b1; bus.wbsel_i = WB_MEM; bus.regwr_i = 1'b1; bus.rd_i = 5'd3;
         bus.funct3_i = f3s[i]; bus.alu_i = {30'h100, offs[i]};
         step();
         bus.valid_i = 1'b0;
         n_cmp++;
         if ({bus.err_o, bus.ready_o, bus.regwren_o, bus.retire_cnt_o} !== {3'b110, 32'd0}) begin
            n_bad++;
            $display("FAIL err_case[%0d] got err=%b rdy=%b wren=%b cnt=%0d want 1 1 0 0",
                     i, bus.err_o, bus.ready_o, bus.regwren_o, bus.retire_cnt_o);
         end
      end
      bus.valid_i = 1'b1; bus.wbsel_i = WB_ALU; bus.rd_i = 5'd7; bus.alu_i = 32'h55;
      step();
      bus.valid_i = 1'b0;
      n_cmp++;
      if ({bus.regwren_o, bus.rd_o, bus.datawb_o, bus.err_o, bus.retire_cnt_o}
          !== {1'b1, 5'd7, 32'h55, 1'b1, 32'd1}) begin
         n_bad++;
         $display("FAIL err_then_alu got wren=%b rd=%0d data=%h err=%b cnt=%0d want 1 7 00000055 1 1",
                  bus.regwren_o, bus.rd_o, bus.datawb_o, bus.err_o, bus.retire_cnt_o);
      end
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      bus.valid_i = 1'b1; bus.wbsel_i = WB_MEM; bus.regwr_i = 1'b1; bus.rd_i = 5'd9;
      bus.funct3_i = F3_LW; bus.alu_i = 32'h200;
      step();
      bus.valid_i = 1'b0;
      for (int i = 1; i < 16; i++) begin
         step();
         n_cmp++;
         if ({bus.ready_o, bus.err_o, bus.regwren_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL timeout_wait[%0d] got rdy=%b err=%b wren=%b want 0 0 0",
                     i, bus.ready_o, bus.err_o, bus.regwren_o);
         end
      end
      step();
      n_cmp++;
      if ({bus.ready_o, bus.err_o, bus.regwren_o, bus.retire_cnt_o} !== {3'b110, 32'd0}) begin
         n_bad++;
         $display("FAIL timeout_fire got rdy=%b err=%b wren=%b cnt=%0d want 1 1 0 0",
                  bus.ready_o, bus.err_o, bus.regwren_o, bus.retire_cnt_o);
      end
      bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1111_2222;
      step();
      step();
      bus.mem_rvalid_i = 1'b0;
      n_cmp++;
      if ({bus.regwren_o, bus.ready_o, bus.retire_cnt_o} !== {2'b01, 32'd0}) begin
         n_bad++;
         $display("FAIL timeout_late_rvalid got wren=%b rdy=%b cnt=%0d want 0 1 0",
                  bus.regwren_o, bus.ready_o, bus.retire_cnt_o);
      end
   endtask

   task automatic test_reset_mid_load();
      bus.valid_i = 1'b1; bus.wbsel_i = WB_ALU; bus.regwr_i = 1'b1; bus.rd_i = 5'd4; bus.alu_i = 32'h77;
      step();
      bus.wbsel_i = WB_MEM; bus.funct3_i = F3_LW; bus.alu_i = 32'h300; bus.rd_i = 5'd8;
      step();
      bus.valid_i = 1'b0;
      step();
      n_cmp++;
      if (bus.ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL midload_waiting got rdy=%b want 0", bus.ready_o);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_F00D;
      step();
      bus.mem_rvalid_i = 1'b0;
      n_cmp++;
      if ({bus.ready_o, bus.regwren_o, bus.err_o, bus.rd_o, bus.datawb_o, bus.retire_cnt_o}
          !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL midload_reset got rdy=%b wren=%b err=%b rd=%0d data=%h cnt=%0d want 1 0 0 0 0 0",
                  bus.ready_o, bus.regwren_o, bus.err_o, bus.rd_o, bus.datawb_o, bus.retire_cnt_o);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_alu_back_to_back();
      test_pc4_x0();
      test_loads();
      test_timeout();
      test_errors();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
